// File: rtl/vga_cursor_timing_gen.sv
// Parametrised VGA raster timing generator with a frame-synchronous cell cursor.
// Optional cursor blinking is compiled in with `define CURSOR_BLINK_EN.
module vga_cursor_timing_gen #(
    parameter int unsigned H_ACTIVE     = 640,
    parameter int unsigned H_FP         = 16,
    parameter int unsigned H_SYNC       = 96,
    parameter int unsigned H_BP         = 48,
    parameter int unsigned V_ACTIVE     = 480,
    parameter int unsigned V_FP         = 10,
    parameter int unsigned V_SYNC       = 2,
    parameter int unsigned V_BP         = 33,
    parameter bit          H_POL        = 1'b0,
    parameter bit          V_POL        = 1'b0,
    parameter int unsigned CELL_W       = 8,
    parameter int unsigned CELL_H       = 16,
    parameter int unsigned BLINK_FRAMES = 30,
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int unsigned COLS    = H_ACTIVE / CELL_W,
    localparam int unsigned ROWS    = V_ACTIVE / CELL_H,
    localparam int unsigned HW      = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1,
    localparam int unsigned VW      = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1,
    localparam int unsigned CW      = (COLS > 1) ? $clog2(COLS) : 1,
    localparam int unsigned RW      = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cursor_adv,
    input  logic          cursor_home,
    output logic          vga_h_sync,
    output logic          vga_v_sync,
    output logic          in_display,
    output logic [HW-1:0] counter_x,
    output logic [VW-1:0] counter_y,
    output logic [CW-1:0] cursor_col,
    output logic [RW-1:0] cursor_row,
    output logic          cursor_on,
    output logic          frame_start
);
    localparam int unsigned SXW = (CELL_W > 1) ? $clog2(CELL_W) : 1;
    localparam int unsigned SYW = (CELL_H > 1) ? $clog2(CELL_H) : 1;

    if ((H_ACTIVE % CELL_W) != 0) begin : g_bad_cell_w
        $error("H_ACTIVE must be a multiple of CELL_W");
    end
    if ((V_ACTIVE % CELL_H) != 0) begin : g_bad_cell_h
        $error("V_ACTIVE must be a multiple of CELL_H");
    end
    if (BLINK_FRAMES == 0) begin : g_bad_blink
        $error("BLINK_FRAMES must be at least 1");
    end

    logic [HW-1:0]  h_cnt, cell_x;
    logic [VW-1:0]  v_cnt, cell_y;
    logic [SXW-1:0] sub_x;
    logic [SYW-1:0] sub_y;
    logic           home_pend, adv_pend, started;

    logic           h_last, v_last, sub_x_last, sub_y_last, origin, frame_tick;
    logic           disp_int, hs_act, vs_act, on_int, visible, moved;
    logic [CW-1:0]  col_d;
    logic [RW-1:0]  row_d;
    logic           home_pend_d, adv_pend_d;

    assign h_last     = (32'(h_cnt) == H_TOTAL - 1);
    assign v_last     = (32'(v_cnt) == V_TOTAL - 1);
    assign sub_x_last = (32'(sub_x) == CELL_W - 1);
    assign sub_y_last = (32'(sub_y) == CELL_H - 1);
    assign origin     = (h_cnt == '0) && (v_cnt == '0);
    assign frame_tick = origin && started;

    assign disp_int = (32'(h_cnt) < H_ACTIVE) && (32'(v_cnt) < V_ACTIVE);
    assign hs_act   = (32'(h_cnt) >= H_ACTIVE + H_FP) && (32'(h_cnt) < H_ACTIVE + H_FP + H_SYNC);
    assign vs_act   = (32'(v_cnt) >= V_ACTIVE + V_FP) && (32'(v_cnt) < V_ACTIVE + V_FP + V_SYNC);

    // Pending requests are applied while the raster sits at (0,0); pulses seen
    // in that same cycle become the pending set for the following frame.
    always_comb begin
        col_d       = cursor_col;
        row_d       = cursor_row;
        home_pend_d = home_pend | cursor_home;
        adv_pend_d  = cursor_home ? 1'b0 : (adv_pend | cursor_adv);
        if (origin) begin
            if (home_pend) begin
                col_d = '0;
                row_d = '0;
            end else if (adv_pend) begin
                if (32'(cursor_col) == COLS - 1) begin
                    col_d = '0;
                    row_d = (32'(cursor_row) == ROWS - 1) ? '0 : cursor_row + 1'b1;
                end else begin
                    col_d = cursor_col + 1'b1;
                end
            end
            home_pend_d = cursor_home;
            adv_pend_d  = cursor_adv & ~cursor_home;
        end
    end

    assign moved = (col_d != cursor_col) || (row_d != cursor_row);

`ifdef CURSOR_BLINK_EN
    localparam int unsigned BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    logic [BW-1:0] blink_cnt, blink_cnt_d;
    logic          phase, phase_d;

    always_comb begin
        blink_cnt_d = blink_cnt;
        phase_d     = phase;
        if (moved) begin
            blink_cnt_d = '0;
            phase_d     = 1'b1;
        end else if (frame_tick) begin
            if (32'(blink_cnt) == BLINK_FRAMES - 1) begin
                blink_cnt_d = '0;
                phase_d     = ~phase;
            end else begin
                blink_cnt_d = blink_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt <= '0;
            phase     <= 1'b1;
        end else begin
            blink_cnt <= blink_cnt_d;
            phase     <= phase_d;
        end
    end

    assign visible = phase_d;
`else
    assign visible = 1'b1;
`endif

    // Compare against the next cursor value so the strobe lines up with the
    // registered cursor_col/cursor_row it is presented alongside.
    assign on_int = disp_int && (cell_x == HW'(col_d)) && (cell_y == VW'(row_d))
                    && sub_y_last && visible;

    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt  <= '0;
            v_cnt  <= '0;
            sub_x  <= '0;
            cell_x <= '0;
            sub_y  <= '0;
            cell_y <= '0;
        end else begin
            if (h_last) begin
                h_cnt  <= '0;
                sub_x  <= '0;
                cell_x <= '0;
                if (v_last) begin
                    v_cnt  <= '0;
                    sub_y  <= '0;
                    cell_y <= '0;
                end else begin
                    v_cnt <= v_cnt + 1'b1;
                    if (sub_y_last) begin
                        sub_y  <= '0;
                        cell_y <= cell_y + 1'b1;
                    end else begin
                        sub_y <= sub_y + 1'b1;
                    end
                end
            end else begin
                h_cnt <= h_cnt + 1'b1;
                if (sub_x_last) begin
                    sub_x  <= '0;
                    cell_x <= cell_x + 1'b1;
                end else begin
                    sub_x <= sub_x + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            started     <= 1'b0;
            home_pend   <= 1'b0;
            adv_pend    <= 1'b0;
            cursor_col  <= '0;
            cursor_row  <= '0;
            counter_x   <= '0;
            counter_y   <= '0;
            vga_h_sync  <= ~H_POL;
            vga_v_sync  <= ~V_POL;
            in_display  <= 1'b0;
            cursor_on   <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            started     <= 1'b1;
            home_pend   <= home_pend_d;
            adv_pend    <= adv_pend_d;
            cursor_col  <= col_d;
            cursor_row  <= row_d;
            counter_x   <= h_cnt;
            counter_y   <= v_cnt;
            vga_h_sync  <= hs_act ? H_POL : ~H_POL;
            vga_v_sync  <= vs_act ? V_POL : ~V_POL;
            in_display  <= disp_int;
            cursor_on   <= on_int;
            frame_start <= frame_tick;
        end
    end
endmodule

// File: tb/tb_vga_cursor_timing_gen.sv
// Scoreboard bench for vga_cursor_timing_gen on a reduced raster; the reference
// model derives every output from the elapsed pixel count since reset.
module tb_vga_cursor_timing_gen;
    localparam int HA = 16, HFP = 2, HS = 3, HBP = 3;
    localparam int VA = 12, VFP = 1, VS = 2, VBP = 1;
    localparam int CWD = 4, CHT = 3, BF = 2;
    localparam bit HPOL = 1'b1, VPOL = 1'b0;
    localparam int HT = HA + HFP + HS + HBP;   // 24
    localparam int VT = VA + VFP + VS + VBP;   // 16
    localparam int NCOL = HA / CWD, NROW = VA / CHT;
    localparam int NCYC = 75 * HT * VT;

    logic       clk = 1'b0;
    logic       rst, cursor_adv, cursor_home;
    logic       vga_h_sync, vga_v_sync, in_display, cursor_on, frame_start;
    logic [4:0] counter_x;
    logic [3:0] counter_y;
    logic [1:0] cursor_col, cursor_row;

    vga_cursor_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .H_POL(HPOL), .V_POL(VPOL),
        .CELL_W(CWD), .CELL_H(CHT), .BLINK_FRAMES(BF)
    ) dut (
        .clk(clk), .rst(rst), .cursor_adv(cursor_adv), .cursor_home(cursor_home),
        .vga_h_sync(vga_h_sync), .vga_v_sync(vga_v_sync), .in_display(in_display),
        .counter_x(counter_x), .counter_y(counter_y),
        .cursor_col(cursor_col), .cursor_row(cursor_row),
        .cursor_on(cursor_on), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       hs, vs, disp;
        logic [4:0] x;
        logic [3:0] y;
        logic [1:0] col, row;
        logic       on, fs;
    } obs_t;

    obs_t q[$];
    int   total = 0, bad = 0;

    int   cnt = 0, mcol = 0, mrow = 0, fsc = 0;
    bit   ph = 0, pa = 0;

    task automatic drive(input bit r, input bit a, input bit h);
        obs_t e;
        int   pos, x, y, fr, oc, orow, lin;
        bit   vis;
        @(negedge clk);
        rst = r; cursor_adv = a; cursor_home = h;
        e = '0;
        if (r) begin
            cnt = 0; ph = 0; pa = 0; mcol = 0; mrow = 0; fsc = 0;
            e.hs = ~HPOL;
            e.vs = ~VPOL;
        end else begin
            pos = cnt;
            x   = pos % HT;
            y   = (pos / HT) % VT;
            fr  = pos / (HT * VT);
            if (x == 0 && y == 0) begin
                oc = mcol; orow = mrow;
                if (ph) begin
                    mcol = 0; mrow = 0;
                end else if (pa) begin
                    lin  = (mrow * NCOL + mcol + 1) % (NCOL * NROW);
                    mcol = lin % NCOL;
                    mrow = lin / NCOL;
                end
                if (fr > 0) begin
                    if (mcol != oc || mrow != orow) fsc = 0;
                    else fsc++;
                end
                ph = h;
                pa = a && !h;
            end else if (h) begin
                ph = 1; pa = 0;
            end else if (a) begin
                pa = 1;
            end
`ifdef CURSOR_BLINK_EN
            vis = ((fsc / BF) % 2) == 0;
`else
            vis = 1'b1;
`endif
            e.hs   = (x >= HA + HFP && x < HA + HFP + HS) ? HPOL : ~HPOL;
            e.vs   = (y >= VA + VFP && y < VA + VFP + VS) ? VPOL : ~VPOL;
            e.disp = (x < HA) && (y < VA);
            e.x    = 5'(x);
            e.y    = 4'(y);
            e.col  = 2'(mcol);
            e.row  = 2'(mrow);
            e.on   = e.disp && (x / CWD == mcol) && (y / CHT == mrow)
                     && (y % CHT == CHT - 1) && vis;
            e.fs   = (x == 0 && y == 0 && fr > 0);
            cnt++;
        end
        q.push_back(e);
    endtask

    initial begin
        obs_t e, act;
        int   cyc;
        cyc = 0;
        @(negedge clk);
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            act = {vga_h_sync, vga_v_sync, in_display, counter_x, counter_y,
                   cursor_col, cursor_row, cursor_on, frame_start};
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL scoreboard_empty cycle=%0d got=%h want=<entry>", cyc, act);
            end else begin
                e = q.pop_front();
                if (act !== e) begin
                    bad++;
                    $display("FAIL outputs cycle=%0d got hs=%b vs=%b disp=%b x=%0d y=%0d col=%0d row=%0d on=%b fs=%b want hs=%b vs=%b disp=%b x=%0d y=%0d col=%0d row=%0d on=%b fs=%b",
                             cyc, act.hs, act.vs, act.disp, act.x, act.y, act.col, act.row, act.on, act.fs,
                             e.hs, e.vs, e.disp, e.x, e.y, e.col, e.row, e.on, e.fs);
                end
            end
        end
    end

    initial begin
        bit did_rst;
        rst = 1'b1; cursor_adv = 1'b0; cursor_home = 1'b0;
        did_rst = 0;
        repeat (3) drive(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < NCYC; i++) begin
            int pos, x, y, fr;
            bit r, a, h;
            pos = cnt;
            x   = pos % HT;
            y   = (pos / HT) % VT;
            fr  = pos / (HT * VT);
            r   = 1'b0;
            a   = ($urandom_range(0, 99) == 0);
            h   = ($urandom_range(0, 1999) == 0);
            if (!did_rst && fr == 20 && x == 10 && y == 7) begin
                r = 1'b1;
                did_rst = 1;
            end
            if (fr == 30 && x == 5 && y == 3) begin
                a = 1'b1; h = 1'b1;
            end
            if (fr == 40 && x == 0 && y == 0) a = 1'b1;
            drive(r, a, h);
        end
        @(posedge clk);
        #2;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain got=%0d entries want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
